alu_div_iter: RTL and testbench

- Parametrised iterative divide unit alongside the single-cycle ALU in the EX stage.
- Executes RISC-V DIV/DIVU/REM/REMU with one restoring-division step per cycle.
- Uses the same enable/ready/ex_ready handshake as the ALU. Adds multi-cycle state, back-pressure holding, and RISC-V corner-case shortcuts.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 23 ++
 rtl/alu_div_iter.sv | 110 +++++++++++
 tb/tb_alu_div_iter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types for the iterative divide unit
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // One extra top bit so the trial subtract's borrow is never lost.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {2'b00, divisor};
  assign borrow   = diff[WIDTH+1];
  assign rem_next = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
  assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/alu_div_iter.sv
// rtl/alu_div_iter.sv - iterative RISC-V DIV/DIVU/REM/REMU unit, one bit per cycle
module alu_div_iter
  import div_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  div_op_e          operator_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  input  logic             ex_ready_i
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q, dvsr_q, result_q;
  logic             is_rem_q, neg_q_q, neg_r_q;

  logic             is_signed, is_rem, a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0] abs_a, abs_b, short_res, q_fix, r_fix;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;

  assign is_signed = (operator_i == DIV) || (operator_i == REM);
  assign is_rem    = (operator_i == REM) || (operator_i == REMU);
  assign a_neg     = is_signed && operand_a_i[WIDTH-1];
  assign b_neg     = is_signed && operand_b_i[WIDTH-1];
  // -2^(WIDTH-1) negates to itself, which is the right unsigned magnitude.
  assign abs_a     = a_neg ? -operand_a_i : operand_a_i;
  assign abs_b     = b_neg ? -operand_b_i : operand_b_i;
  assign div_zero  = (operand_b_i == '0);
  assign ovf       = is_signed && (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}})
                     && (operand_b_i == '1);

  always_comb begin
    short_res = '0;
    if (div_zero)
      short_res = is_rem ? operand_a_i : '1;
    else if (ovf)
      short_res = is_rem ? '0 : operand_a_i;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  assign q_fix = neg_q_q ? -quo_nx : quo_nx;
  assign r_fix = neg_r_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = (div_zero || ovf) ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (ex_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (enable_i) begin
          is_rem_q <= is_rem;
          neg_q_q  <= a_neg ^ b_neg;
          neg_r_q  <= a_neg;
          rem_q    <= '0;
          quo_q    <= abs_a;
          dvsr_q   <= abs_b;
          cnt_q    <= CNT_W'(WIDTH);
          if (div_zero || ovf) result_q <= short_res;
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) result_q <= is_rem_q ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = rst_n && (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_alu_div_iter.sv
// tb/tb_alu_div_iter.sv - directed self-checking bench for alu_div_iter
module tb_alu_div_iter;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  div_op_e     operator_i = DIVU;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        ready_o, valid_o;
  logic [31:0] result_o;
  logic        ex_ready_i = 1'b1;

  int checks = 0;
  int errors = 0;

  alu_div_iter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .operator_i  (operator_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .result_o    (result_o),
    .ex_ready_i  (ex_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input div_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    enable_i    = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    ex_ready_i  = 1'b1;
    @(negedge clk);
    enable_i    = 1'b0;
    operand_a_i = $urandom;
    operand_b_i = $urandom;
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    check({tag, "_valid_clr"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, ready_o}, 32'd1);
    check("idle_valid", {31'd0, valid_o}, 32'd0);

    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0", REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Back-pressure: result must hold while the consumer stalls.
    @(negedge clk);
    enable_i    = 1'b1;
    operator_i  = DIVU;
    operand_a_i = 32'd1000;
    operand_b_i = 32'd10;
    ex_ready_i  = 1'b0;
    @(negedge clk);
    enable_i = 1'b0;
    wait_valid(lat);
    check("hold_lat", 32'(lat), 32'd33);
    check("hold_res", result_o, 32'd100);
    for (int i = 0; i < 5; i++) begin
      enable_i    = 1'b1;
      operator_i  = DIVU;
      operand_a_i = $urandom;
      operand_b_i = 32'd0;
      @(negedge clk);
      check("hold_valid", {31'd0, valid_o}, 32'd1);
      check("hold_res_stable", result_o, 32'd100);
      check("hold_not_ready", {31'd0, ready_o}, 32'd0);
    end
    enable_i   = 1'b0;
    ex_ready_i = 1'b1;
    @(negedge clk);
    check("release_ready", {31'd0, ready_o}, 32'd1);
    check("release_valid", {31'd0, valid_o}, 32'd0);

    // Reset in the middle of a calculation aborts it.
    @(negedge clk);
    enable_i    = 1'b1;
    operator_i  = DIVU;
    operand_a_i = 32'd1000;
    operand_b_i = 32'd7;
    @(negedge clk);
    enable_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_valid", {31'd0, valid_o}, 32'd0);
    check("abort_result", result_o, 32'd0);
    check("abort_ready_gated", {31'd0, ready_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", {31'd0, ready_o}, 32'd1);
    run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
